dc_run_ctrl: RTL and testbench
==============================

Name: dc_run_ctrl

Overview:
Run controller for the two-digit decade (BCD) counter datapath. It turns raw control pulses (start, stop, clear) into a sequenced count run. It prescales the count enable, steps the ones/tens digits, and flags arrival at a programmable BCD target with a one-cycle z pulse. It sits between the bench/board inputs and the counter display path and owns all run/hold/done sequencing.

Parameters:
PRESCALE, 4, clk cycles per count step in RUN; legal range 1..16.

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  level input; rising edge = start/resume request
stop  input  1  level input; rising edge = pause request
clear  input  1  level input; rising edge = abort to IDLE, zero counts
target  input  8  BCD target; [7:4] tens, [3:0] ones; sampled every cycle
ones  output  4  BCD ones digit
tens  output  4  BCD tens digit
cnt_en  output  1  high in the cycle a count step is committed
z  output  1  one-cycle pulse when count reaches target
busy  output  1  high in RUN or HOLD
state  output  2  IDLE=00, RUN=01, HOLD=10, DONE=11

Behaviour:
- Reset: one clk with reset=1 gives state=IDLE, ones=0, tens=0, prescaler=0, z=0.
  - cnt_en=0, busy=0.
  - Edge-detect history registers load 1, so an input already high at reset release is not an edge.
- Edge detect: edge = in & ~prev; prev is registered each cycle.
  - An edge sampled at edge n takes effect at n (state visible after n).
- Priority when edges coincide: clear > stop > start.
- clear edge, any state: next state IDLE, counts 00, prescaler 0, z=0.
- IDLE:
  - start edge: go to RUN, counts 00, prescaler 0.
  - stop is ignored.
- RUN:
  - Prescaler increments each cycle.
  - cnt_en = (state==RUN && prescaler==PRESCALE-1), decoded from registers.
  - On a cnt_en cycle, the prescaler wraps to 0 and the count steps:
    - ones 9 wraps to 0 and increments tens.
    - tens 9 with ones 9 wraps to 00.
  - Compare uses the next count value. If it equals target, the next state is DONE and z=1 for exactly that one following cycle.
  - stop edge: go to HOLD; the prescaler and counts freeze at their current values.
  - A stop edge in the same cycle as cnt_en: the step is suppressed.
- HOLD:
  - start edge: go to RUN, continuing from the frozen prescaler value.
  - stop is ignored.
- DONE:
  - Counts hold; busy=0.
  - start edge: go to RUN with counts 00 and prescaler 0.
  - stop is ignored.
- Target handling:
  - Target with either nibble >9 never matches; the counter free-runs with 99→00 wrap.
  - Target 00 matches only on the 99→00 wrap, not at run start.
  - A target change mid-run takes effect at the next compare.
  - A target already passed is not matched until wrap-around.
- Outputs: z, counts and state are registered. cnt_en and busy are decoded from state/prescaler registers, with no input-to-output combinational path.

Test Plan:
- Reset and release with start held high:
  - During reset: state=00, ones/tens=0, z/busy/cnt_en=0.
  - 10 cycles after release: still IDLE (no edge).
- Basic run, target=0x03, PRESCALE=4, start pulse:
  - RUN next cycle.
  - cnt_en every 4th cycle; ones goes 1,2,3 at RUN cycles 4,8,12.
  - z high for one cycle with ones=3; state=11; counts hold 20 more cycles.
- Digit carry, target=0x10:
  - ones 9→0 with tens 0→1 on the 10th step (RUN cycle 40).
  - z pulses once; DONE.
- Pause/resume:
  - stop edge when ones=2 and prescaler=1: HOLD, busy=1.
  - Counts and prescaler frozen for 10 cycles.
  - start edge: next step 3 cycles later, ones=3.
- Simultaneous events:
  - clear+start edges in RUN: go to IDLE, 00.
  - stop edge coinciding with cnt_en: HOLD, count unchanged.
  - start in DONE: restarts from 00.
- Wrap and invalid target:
  - target=0xA5: 100 steps, 99→00 wrap observed, z never asserts.
  - target=0x00: z on the 100th step exactly.

Source files
------------

// File: rtl/dc_run_ctrl_if.sv
// Control/status bundle for the decade-counter run controller.
// The bench or board side holds master; the controller holds slave.
interface dc_run_ctrl_if;
  logic       start;
  logic       stop;
  logic       clear;
  logic [7:0] target;
  logic [3:0] ones;
  logic [3:0] tens;
  logic       cnt_en;
  logic       z;
  logic       busy;
  logic [1:0] state;

  modport master (
    output start, stop, clear, target,
    input  ones, tens, cnt_en, z, busy, state
  );

  modport slave (
    input  start, stop, clear, target,
    output ones, tens, cnt_en, z, busy, state
  );
endinterface

// File: rtl/dc_run_ctrl.sv
// Run controller for a two-digit BCD counter: edge-detects start/stop/clear,
// prescales the count enable, steps the digits and pulses z on reaching target.
module dc_run_ctrl #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic         clk,
  input  logic         reset,
  dc_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HOLD = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam logic [3:0] PRE_MAX = 4'(PRESCALE - 1);

  state_e     state_q, state_d;
  logic [3:0] ones_q, ones_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] pre_q, pre_d;
  logic       z_q, z_d;
  logic       start_prev_q, start_prev_d;
  logic       stop_prev_q, stop_prev_d;
  logic       clear_prev_q, clear_prev_d;

  logic       start_edge, stop_edge, clear_edge;
  logic       cnt_en;
  logic [3:0] ones_step, tens_step;

  assign start_edge = bus.start & ~start_prev_q;
  assign stop_edge  = bus.stop  & ~stop_prev_q;
  assign clear_edge = bus.clear & ~clear_prev_q;

  // Decoded purely from registers so no input reaches an output combinationally.
  assign cnt_en = (state_q == RUN) && (pre_q == PRE_MAX);

  // BCD increment with 99 -> 00 wrap.
  always_comb begin
    ones_step = ones_q + 4'd1;
    tens_step = tens_q;
    if (ones_q == 4'd9) begin
      ones_step = 4'd0;
      tens_step = (tens_q == 4'd9) ? 4'd0 : tens_q + 4'd1;
    end
  end

  // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latches).
  always_comb begin
    state_d      = state_q;
    ones_d       = ones_q;
    tens_d       = tens_q;
    pre_d        = pre_q;
    z_d          = 1'b0;
    start_prev_d = bus.start;
    stop_prev_d  = bus.stop;
    clear_prev_d = bus.clear;

    if (clear_edge) begin
      state_d = IDLE;
      ones_d  = 4'd0;
      tens_d  = 4'd0;
      pre_d   = 4'd0;
    end else begin
      unique case (state_q)
        IDLE, DONE: begin
          if (start_edge) begin
            state_d = RUN;
            ones_d  = 4'd0;
            tens_d  = 4'd0;
            pre_d   = 4'd0;
          end
        end
        RUN: begin
          // A pause wins over a coincident step: everything freezes as-is.
          if (stop_edge) begin
            state_d = HOLD;
          end else if (cnt_en) begin
            pre_d  = 4'd0;
            ones_d = ones_step;
            tens_d = tens_step;
            // Invalid BCD targets can never equal a stepped count, so they never match.
            if ({tens_step, ones_step} == bus.target) begin
              state_d = DONE;
              z_d     = 1'b1;
            end
          end else begin
            pre_d = pre_q + 4'd1;
          end
        end
        HOLD: begin
          if (start_edge) state_d = RUN;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      ones_q       <= 4'd0;
      tens_q       <= 4'd0;
      pre_q        <= 4'd0;
      z_q          <= 1'b0;
      // History loads 1 so a level already high at release is not an edge.
      start_prev_q <= 1'b1;
      stop_prev_q  <= 1'b1;
      clear_prev_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      ones_q       <= ones_d;
      tens_q       <= tens_d;
      pre_q        <= pre_d;
      z_q          <= z_d;
      start_prev_q <= start_prev_d;
      stop_prev_q  <= stop_prev_d;
      clear_prev_q <= clear_prev_d;
    end
  end

  assign bus.ones   = ones_q;
  assign bus.tens   = tens_q;
  assign bus.z      = z_q;
  assign bus.state  = state_q;
  assign bus.cnt_en = cnt_en;
  assign bus.busy   = (state_q == RUN) || (state_q == HOLD);

  a_digits_bcd: assert property (@(posedge clk) disable iff (reset)
    (ones_q <= 4'd9) && (tens_q <= 4'd9));

  a_z_only_done: assert property (@(posedge clk) disable iff (reset)
    z_q |-> (state_q == DONE));

  a_pre_in_range: assert property (@(posedge clk) disable iff (reset)
    pre_q <= PRE_MAX);

endmodule

// File: tb/tb_dc_run_ctrl.sv
// Directed bench for dc_run_ctrl with PRESCALE=4; expected values hand-derived.
module tb_dc_run_ctrl;

  localparam int PRESCALE = 4;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  dc_run_ctrl_if bus ();

  dc_run_ctrl #(.PRESCALE(PRESCALE)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic pulse_clear();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    tick();
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v % 100) / 10) << 4) | 8'((v % 100) % 10);
  endfunction

  initial begin
    logic z_seen;

    // Reset with start already high.
    reset      = 1'b1;
    bus.start  = 1'b1;
    bus.stop   = 1'b0;
    bus.clear  = 1'b0;
    bus.target = 8'h03;
    tick(2);
    check("rst_state",  bus.state,  2'b00);
    check("rst_count",  {bus.tens, bus.ones}, 8'h00);
    check("rst_z",      bus.z,      1'b0);
    check("rst_busy",   bus.busy,   1'b0);
    check("rst_cnt_en", bus.cnt_en, 1'b0);
    reset = 1'b0;
    tick(10);
    check("held_start_idle", bus.state, 2'b00);
    bus.start = 1'b0;
    tick();

    // Stop in IDLE is ignored.
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    tick();
    check("idle_stop_ignored", bus.state, 2'b00);

    // Basic run to target 03.
    pulse_start();
    check("run_state", bus.state, 2'b01);
    check("run_busy",  bus.busy,  1'b1);
    for (int s = 1; s <= 3; s++) begin
      tick(PRESCALE - 1);
      check($sformatf("step%0d_cnt_en", s), bus.cnt_en, 1'b1);
      tick();
      check($sformatf("step%0d_ones", s), bus.ones, 32'(s));
      if (s < 3) check($sformatf("step%0d_no_en", s), bus.cnt_en, 1'b0);
    end
    check("t03_z",     bus.z,     1'b1);
    check("t03_state", bus.state, 2'b11);
    check("t03_busy",  bus.busy,  1'b0);
    tick();
    check("t03_z_pulse", bus.z, 1'b0);
    tick(20);
    check("t03_hold_count", {bus.tens, bus.ones}, 8'h03);
    check("t03_hold_state", bus.state, 2'b11);

    // Digit carry, target 10; start from DONE restarts at 00.
    bus.target = 8'h10;
    pulse_start();
    check("done_restart_state", bus.state, 2'b01);
    check("done_restart_count", {bus.tens, bus.ones}, 8'h00);
    tick(39);
    check("carry_pre_count", {bus.tens, bus.ones}, 8'h09);
    check("carry_pre_z",     bus.z, 1'b0);
    tick();
    check("carry_count", {bus.tens, bus.ones}, 8'h10);
    check("carry_z",     bus.z,     1'b1);
    check("carry_state", bus.state, 2'b11);
    tick();
    check("carry_z_pulse", bus.z, 1'b0);

    // Pause at ones=2, prescaler=1, then resume.
    bus.target = 8'h50;
    pulse_start();
    tick(9);
    check("pause_pre_count", {bus.tens, bus.ones}, 8'h02);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("pause_state", bus.state, 2'b10);
    check("pause_busy",  bus.busy,  1'b1);
    tick(10);
    check("pause_frozen_count", {bus.tens, bus.ones}, 8'h02);
    check("pause_frozen_state", bus.state, 2'b10);
    check("pause_no_en",        bus.cnt_en, 1'b0);
    pulse_start();
    check("resume_state", bus.state, 2'b01);
    tick(2);
    check("resume_en",        bus.cnt_en, 1'b1);
    check("resume_pre_count", bus.ones,   4'd2);
    tick();
    check("resume_count", {bus.tens, bus.ones}, 8'h03);

    // Clear and start together in RUN: clear wins.
    bus.clear = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.clear = 1'b0;
    bus.start = 1'b0;
    check("clr_start_state", bus.state, 2'b00);
    check("clr_start_count", {bus.tens, bus.ones}, 8'h00);
    tick();

    // Stop coinciding with cnt_en suppresses the step.
    pulse_start();
    tick(PRESCALE - 1);
    check("stop_en_cnt_en", bus.cnt_en, 1'b1);
    bus.stop = 1'b1;
    tick();
    bus.stop = 1'b0;
    check("stop_en_state", bus.state, 2'b10);
    check("stop_en_count", {bus.tens, bus.ones}, 8'h00);
    tick(5);
    check("stop_en_still", {bus.tens, bus.ones}, 8'h00);
    pulse_clear();
    check("clear_from_hold", bus.state, 2'b00);

    // Invalid target: free-run through the 99 -> 00 wrap, z never fires.
    bus.target = 8'hA5;
    pulse_start();
    z_seen = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      tick(PRESCALE);
      z_seen |= bus.z;
      check($sformatf("free_step%0d", i), {bus.tens, bus.ones}, to_bcd(i));
    end
    check("free_state", bus.state, 2'b01);
    check("free_no_z",  z_seen,    1'b0);

    // Target 00: no match at run start, match exactly on the 100th step.
    pulse_clear();
    bus.target = 8'h00;
    pulse_start();
    check("t00_start_state", bus.state, 2'b01);
    z_seen = 1'b0;
    for (int i = 1; i <= 99; i++) begin
      tick(PRESCALE);
      z_seen |= bus.z;
    end
    check("t00_pre_z",     z_seen,    1'b0);
    check("t00_pre_count", {bus.tens, bus.ones}, 8'h99);
    check("t00_pre_state", bus.state, 2'b01);
    tick(PRESCALE);
    check("t00_z",     bus.z,     1'b1);
    check("t00_state", bus.state, 2'b11);
    check("t00_count", {bus.tens, bus.ones}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
